// File: rtl/stage_mem_if.sv
// rtl/stage_mem_if.sv - data bus bundle between the memory stage and the data memory
interface stage_mem_if;
   logic [31:0] dbus_addr_o;
   logic [31:0] dbus_dat_o;
   logic [3:0]  dbus_sel_o;
   logic        dbus_we_o;
   logic        dbus_cyc_o;
   logic [31:0] dbus_dat_i;
   logic        dbus_ack_i;

   // stage_mem side: issues cycles, receives read data and ack
   modport master (
      output dbus_addr_o, dbus_dat_o, dbus_sel_o, dbus_we_o, dbus_cyc_o,
      input  dbus_dat_i, dbus_ack_i
   );

   // memory side
   modport slave (
      input  dbus_addr_o, dbus_dat_o, dbus_sel_o, dbus_we_o, dbus_cyc_o,
      output dbus_dat_i, dbus_ack_i
   );
endinterface

// File: rtl/stage_mem.sv
// rtl/stage_mem.sv - RV32I memory stage: load/store bus access and write-back register
module stage_mem (
   input  logic        clk_i,
   input  logic        rst_i,
   // upstream (execute)
   input  logic [31:0] pc_i,
   input  logic [31:0] instruction_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] alu_d_i,
   input  logic [31:0] rs2_d_i,
   input  logic        valid_i,
   input  logic        e_illegal_inst_i,
   input  logic        e_inst_addr_mis_i,
   input  logic        flush_i,
   output logic        stall_o,
   // data bus
   stage_mem_if.master dbus,
   // write-back register
   output logic [31:0] pc_o,
   output logic [31:0] instruction_o,
   output logic [2:0]  funct3_o,
   output logic [31:0] alu_d_o,
   output logic [31:0] mem_d_o,
   output logic [31:0] mem_addr_o,
   output logic        e_illegal_inst_o,
   output logic        e_inst_addr_mis_o,
   output logic        e_ld_addr_mis_o,
   output logic        e_st_addr_mis_o,
   output logic        valid_o
);

   localparam logic [31:0] NOP          = 32'h0000_0013;
   localparam logic [6:0]  OPC_LOAD     = 7'b0000011;
   localparam logic [6:0]  OPC_STORE    = 7'b0100011;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      r_state;
   state_t      w_next;

   // context of the access in flight, captured when the cycle is issued
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic [2:0]  r_f3;
   logic [31:0] r_alu;
   logic        r_load;
   logic        r_flushed;

   logic        w_is_load;
   logic        w_is_store;
   logic        w_misal;
   logic        w_exc_in;
   logic        w_issue;
   logic        w_pass;
   logic        w_complete;
   logic        w_ack_wait;
   logic [31:0] w_st_dat;
   logic [3:0]  w_st_sel;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ld_fmt;

   assign w_is_load  = (instruction_i[6:0] == OPC_LOAD);
   assign w_is_store = (instruction_i[6:0] == OPC_STORE);
   assign w_exc_in   = e_illegal_inst_i | e_inst_addr_mis_i;

   // alignment check is driven by the access size in funct3[1:0]
   always_comb begin
      w_misal = 1'b0;
      case (funct3_i[1:0])
         2'b01:   w_misal = alu_d_i[0];
         2'b10:   w_misal = (alu_d_i[1:0] != 2'b00);
         default: w_misal = 1'b0;
      endcase
   end

   assign w_issue    = (r_state == S_IDLE) && valid_i && (w_is_load || w_is_store)
                       && !w_misal && !w_exc_in && !flush_i;
   assign w_pass     = (r_state == S_IDLE) && valid_i && !flush_i && !w_issue;
   assign w_ack_wait = (r_state == S_WAIT) && dbus.dbus_ack_i;
   assign w_complete = w_ack_wait && !r_flushed && !flush_i;

   // store lane replication and byte enables
   always_comb begin
      w_st_dat = rs2_d_i;
      w_st_sel = 4'b1111;
      if (w_is_store) begin
         case (funct3_i[1:0])
            2'b00: begin
               w_st_dat = {4{rs2_d_i[7:0]}};
               w_st_sel = 4'b0001 << alu_d_i[1:0];
            end
            2'b01: begin
               w_st_dat = {2{rs2_d_i[15:0]}};
               w_st_sel = alu_d_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
               w_st_dat = rs2_d_i;
               w_st_sel = 4'b1111;
            end
         endcase
      end
   end

   // load data lane selection and sign/zero extension
   always_comb begin
      w_byte   = 8'h00;
      w_half   = 16'h0000;
      w_ld_fmt = dbus.dbus_dat_i;
      case (r_alu[1:0])
         2'b00:   w_byte = dbus.dbus_dat_i[7:0];
         2'b01:   w_byte = dbus.dbus_dat_i[15:8];
         2'b10:   w_byte = dbus.dbus_dat_i[23:16];
         default: w_byte = dbus.dbus_dat_i[31:24];
      endcase
      w_half = r_alu[1] ? dbus.dbus_dat_i[31:16] : dbus.dbus_dat_i[15:0];
      case (r_f3[1:0])
         2'b00:   w_ld_fmt = {{24{!r_f3[2] & w_byte[7]}}, w_byte};
         2'b01:   w_ld_fmt = {{16{!r_f3[2] & w_half[15]}}, w_half};
         default: w_ld_fmt = dbus.dbus_dat_i;
      endcase
   end

   // next state and stall; stall is held low while in reset
   always_comb begin
      w_next  = r_state;
      stall_o = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_issue) begin
               w_next  = S_WAIT;
               stall_o = 1'b1;
            end
         end
         S_WAIT: begin
            stall_o = !dbus.dbus_ack_i;
            if (dbus.dbus_ack_i) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
      if (rst_i) begin
         stall_o = 1'b0;
      end
   end

   // state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // remember a flush seen while waiting so the late result is discarded
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_flushed <= 1'b0;
      end else if (r_state == S_WAIT && !dbus.dbus_ack_i) begin
         r_flushed <= r_flushed | flush_i;
      end else begin
         r_flushed <= 1'b0;
      end
   end

   // capture the instruction context at issue
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pc   <= 32'h0;
         r_inst <= 32'h0;
         r_f3   <= 3'b000;
         r_alu  <= 32'h0;
         r_load <= 1'b0;
      end else if (w_issue) begin
         r_pc   <= pc_i;
         r_inst <= instruction_i;
         r_f3   <= funct3_i;
         r_alu  <= alu_d_i;
         r_load <= w_is_load;
      end
   end

   // bus request registers: set on issue, held until ack
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dbus.dbus_addr_o <= 32'h0;
         dbus.dbus_dat_o  <= 32'h0;
         dbus.dbus_sel_o  <= 4'b0000;
         dbus.dbus_we_o   <= 1'b0;
         dbus.dbus_cyc_o  <= 1'b0;
      end else if (w_issue) begin
         dbus.dbus_addr_o <= {alu_d_i[31:2], 2'b00};
         dbus.dbus_dat_o  <= w_is_store ? w_st_dat : 32'h0;
         dbus.dbus_sel_o  <= w_st_sel;
         dbus.dbus_we_o   <= w_is_store;
         dbus.dbus_cyc_o  <= 1'b1;
      end else if (w_ack_wait) begin
         dbus.dbus_we_o   <= 1'b0;
         dbus.dbus_cyc_o  <= 1'b0;
      end
   end

   // write-back register: bubble unless an instruction is delivered this cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_o              <= 32'h0;
         instruction_o     <= NOP;
         funct3_o          <= 3'b000;
         alu_d_o           <= 32'h0;
         mem_d_o           <= 32'h0;
         mem_addr_o        <= 32'h0;
         e_illegal_inst_o  <= 1'b0;
         e_inst_addr_mis_o <= 1'b0;
         e_ld_addr_mis_o   <= 1'b0;
         e_st_addr_mis_o   <= 1'b0;
         valid_o           <= 1'b0;
      end else begin
         pc_o              <= 32'h0;
         instruction_o     <= NOP;
         funct3_o          <= 3'b000;
         alu_d_o           <= 32'h0;
         mem_d_o           <= 32'h0;
         mem_addr_o        <= 32'h0;
         e_illegal_inst_o  <= 1'b0;
         e_inst_addr_mis_o <= 1'b0;
         e_ld_addr_mis_o   <= 1'b0;
         e_st_addr_mis_o   <= 1'b0;
         valid_o           <= 1'b0;
         if (w_pass) begin
            pc_o              <= pc_i;
            instruction_o     <= instruction_i;
            funct3_o          <= funct3_i;
            alu_d_o           <= alu_d_i;
            mem_addr_o        <= alu_d_i;
            e_illegal_inst_o  <= e_illegal_inst_i;
            e_inst_addr_mis_o <= !e_illegal_inst_i && e_inst_addr_mis_i;
            e_ld_addr_mis_o   <= !w_exc_in && w_is_load && w_misal;
            e_st_addr_mis_o   <= !w_exc_in && w_is_store && w_misal;
            valid_o           <= 1'b1;
         end else if (w_complete) begin
            pc_o          <= r_pc;
            instruction_o <= r_inst;
            funct3_o      <= r_f3;
            alu_d_o       <= r_alu;
            mem_addr_o    <= r_alu;
            mem_d_o       <= r_load ? w_ld_fmt : 32'h0;
            valid_o       <= 1'b1;
         end
      end
   end

endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 Parameters: none; all widths fixed (RV32I).
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  asynchronous, active-high reset.
REQ-004 Upstream (execute) inputs:
- pc_i  in  32  instruction PC.
- instruction_i  in  32  instruction word.
- funct3_i  in  3  instruction funct3.
- alu_d_i  in  32  ALU result; effective address for load/store.
- rs2_d_i  in  32  store data.
- valid_i  in  1  inputs hold a live instruction.
- e_illegal_inst_i, e_inst_addr_mis_i  in  1 each  exceptions from earlier stages.
REQ-005 flush_i  in  1  exception taken in write-back; kill the instruction held here.
REQ-006 stall_o  out  1  upstream holds all inputs stable while high.
REQ-007 Data bus (classic handshake):
- dbus_addr_o  out  32  word address {addr[31:2],2'b00}.
- dbus_dat_o  out  32  write data.
- dbus_sel_o  out  4  byte enables.
- dbus_we_o  out  1  1 = store.
- dbus_cyc_o  out  1  cycle request.
- dbus_dat_i  in  32  read data.
- dbus_ack_i  in  1  completes the cycle.
REQ-008 Write-back outputs, all registered:
- pc_o, instruction_o, funct3_o, alu_d_o  out  32/32/3/32  forwarded fields.
- mem_d_o  out  32  formatted load data.
- mem_addr_o  out  32  full byte address.
- e_illegal_inst_o, e_inst_addr_mis_o, e_ld_addr_mis_o, e_st_addr_mis_o  out  1 each  exceptions.
- valid_o  out  1  write-back register holds a live instruction.

Function
REQ-009 LOAD = opcode 0000011; STORE = opcode 0100011; every other opcode is a non-memory instruction.
REQ-010 Misalignment is defined by funct3[1:0] and addr = alu_d_i:
- halfword (01) is misaligned when addr[0] = 1.
- word (10) is misaligned when addr[1:0] != 0.
- a misaligned load sets e_ld_addr_mis_o; a misaligned store sets e_st_addr_mis_o; neither issues a bus cycle.
REQ-011 FSM has two states, IDLE and WAIT.
REQ-012 IDLE, issuing an access: a valid, aligned load/store with no incoming exception and flush_i = 0 drives stall_o = 1 combinationally, registers the bus outputs with dbus_cyc_o = 1, and moves to WAIT.
REQ-013 IDLE, any other valid instruction: passes through to the write-back register in 1 cycle, with stall_o = 0.
REQ-014 WAIT: stall_o = !dbus_ack_i. Bus outputs are held until ack. On ack:
- dbus_cyc_o = 0 next cycle.
- formatted data is captured into mem_d_o with valid_o = 1 next cycle.
- FSM returns to IDLE.
- a new access is accepted in IDLE no earlier than the cycle after ack (minimum 1 idle cycle between accesses).
REQ-015 Load latency: valid_o rises exactly 1 cycle after the cycle in which dbus_ack_i is sampled high; minimum total latency is 2 cycles.
REQ-016 Store lanes:
- SB: dat_o = {4{rs2[7:0]}}, sel_o = 0001 << addr[1:0].
- SH: dat_o = {2{rs2[15:0]}}, sel_o = 0011 << {addr[1],0}.
- SW: dat_o = rs2, sel_o = 1111.
- loads drive sel_o = 1111 and dbus_we_o = 0.
REQ-017 Load formatting:
- LB/LBU select byte addr[1:0], then sign- or zero-extend.
- LH/LHU select half addr[1], then sign- or zero-extend.
- LW passes the word through.
REQ-018 Bubble: any cycle with no instruction delivered loads the write-back register with instruction_o = 0x00000013, all exceptions 0, and valid_o = 0. This covers stall cycles, valid_i = 0, and flush.
REQ-019 flush_i in IDLE suppresses the bus cycle and delivers a bubble.
REQ-020 flush_i in WAIT does not abort the bus cycle; it runs to ack, the result is discarded, and a bubble is delivered.
REQ-021 Exceptions pass through in 1 cycle and never issue a bus cycle. Priority: e_illegal_inst > e_inst_addr_mis > misaligned load/store.

Reset
REQ-022 While rst_i is high, asynchronously:
- FSM = IDLE.
- dbus_cyc_o = 0 and dbus_we_o = 0.
- stall_o = 0.
- valid_o = 0.
- instruction_o = 0x00000013.
- all other outputs = 0.
REQ-023 Reset asserted in WAIT drops dbus_cyc_o immediately; a late ack after release is ignored.

Verification
REQ-024 LW, addr 0x100, ack after 3 wait cycles, dat_i = 0xDEADBEEF -> stall_o high 4 cycles, then mem_d_o = 0xDEADBEEF and valid_o = 1.
REQ-025 LB, addr 0x103, dat_i = 0x80FFFFFF -> mem_d_o = 0xFFFFFF80; same access as LBU -> 0x00000080.
REQ-026 SH, addr 0x202, rs2 = 0x0000ABCD -> dat_o = 0xABCDABCD, sel_o = 1100, we_o = 1, dbus_addr_o = 0x200.
REQ-027 LW, addr 0x101 -> no dbus_cyc_o, e_ld_addr_mis_o = 1, mem_addr_o = 0x101; SH, addr 0x201 -> e_st_addr_mis_o = 1.
REQ-028 flush_i pulsed during WAIT of LW -> cycle held until ack, then bubble (0x00000013, valid_o = 0).
REQ-029 rst_i asserted mid-WAIT -> dbus_cyc_o = 0 in the same cycle; after release, ack is ignored and valid_o stays 0.
